// File: rtl/card_select_ctrl.sv
// card_select_ctrl: player-input front end for the 6x6 memory-match game.
// Turns button presses into a cursor, two card selections and a found-pair
// verdict. Fetches card values from the card memory, compares them and keeps
// the matched-position mask and the pair count.
// Optional feature: define CURSOR_WRAP_EN to make the cursor wrap at grid
// edges; without it, moves past an edge leave the cursor where it is.
module card_select_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    output logic [5:0]  mem_addr,
    input  logic [4:0]  mem_data,
    output logic [5:0]  mem6x6,
    output logic [5:0]  card1,
    output logic [5:0]  card2,
    output logic [4:0]  data1,
    output logic [4:0]  data2,
    output logic        A,
    output logic        FP,
    output logic [35:0] found,
    output logic [4:0]  pairs,
    output logic        done
);

`ifdef CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH1  = 4'd1;
    localparam logic [3:0] S_LOAD1   = 4'd2;
    localparam logic [3:0] S_WAIT2   = 4'd3;
    localparam logic [3:0] S_FETCH2  = 4'd4;
    localparam logic [3:0] S_LOAD2   = 4'd5;
    localparam logic [3:0] S_COMPARE = 4'd6;
    localparam logic [3:0] S_HOLD    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0] state;
    logic [7:0] hold_cnt;

    // Button vector: [0]=up [1]=down [2]=left [3]=right [4]=sel
    logic [4:0] btn_now;
    logic [4:0] btn_prev;
    logic [4:0] press;

    logic [2:0] row;
    logic [2:0] col;
    logic [5:0] cursor_next;
    logic       sel_ok;
    logic [4:0] pairs_inc;

    assign btn_now   = {btn_sel, btn_right, btn_left, btn_down, btn_up};
    assign press     = btn_now & ~btn_prev;
    assign sel_ok    = press[4] && !found[mem6x6];
    assign pairs_inc = pairs + 5'd1;

    // Previous-sample registers; reset high so a button held through reset is not a press
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_prev <= '1;
        end else begin
            btn_prev <= btn_now;
        end
    end

    // Next cursor position: one move per cycle, priority up > down > left > right
    always_comb begin
        row         = 3'(mem6x6 / 6'd6);
        col         = 3'(mem6x6 % 6'd6);
        cursor_next = mem6x6;
        if (press[0]) begin
            if (row != 3'd0)      cursor_next = mem6x6 - 6'd6;
            else if (WRAP)        cursor_next = mem6x6 + 6'd30;
        end else if (press[1]) begin
            if (row != 3'd5)      cursor_next = mem6x6 + 6'd6;
            else if (WRAP)        cursor_next = mem6x6 - 6'd30;
        end else if (press[2]) begin
            if (col != 3'd0)      cursor_next = mem6x6 - 6'd1;
            else if (WRAP)        cursor_next = mem6x6 + 6'd5;
        end else if (press[3]) begin
            if (col != 3'd5)      cursor_next = mem6x6 + 6'd1;
            else if (WRAP)        cursor_next = mem6x6 - 6'd5;
        end
    end

    // Selection FSM, cursor register, card fetch/compare and found-pair bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            mem6x6   <= '0;
            mem_addr <= '0;
            card1    <= '0;
            card2    <= '0;
            data1    <= '0;
            data2    <= '0;
            A        <= 1'b0;
            FP       <= 1'b1;
            found    <= '0;
            pairs    <= '0;
            done     <= 1'b0;
        end else begin
            A  <= 1'b0;
            FP <= 1'b1;
            // The select below reads the pre-move cursor, so a same-cycle move is harmless
            if (state != S_DONE) begin
                mem6x6 <= cursor_next;
            end
            case (state)
                S_IDLE: begin
                    if (sel_ok) begin
                        card1    <= mem6x6;
                        mem_addr <= mem6x6;
                        A        <= 1'b1;
                        state    <= S_FETCH1;
                    end
                end
                S_FETCH1: state <= S_LOAD1;
                S_LOAD1: begin
                    data1 <= mem_data;
                    state <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (sel_ok && (mem6x6 != card1)) begin
                        card2    <= mem6x6;
                        mem_addr <= mem6x6;
                        A        <= 1'b1;
                        state    <= S_FETCH2;
                    end
                end
                S_FETCH2: state <= S_LOAD2;
                S_LOAD2: begin
                    data2 <= mem_data;
                    state <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (data1 == data2) begin
                        found[card1] <= 1'b1;
                        found[card2] <= 1'b1;
                        pairs        <= pairs_inc;
                        FP           <= 1'b0;
                        if (pairs_inc == 5'd18) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        hold_cnt <= 8'(HOLD_CYCLES);
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt <= 8'd1) begin
                        hold_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
